// File: rtl/tick_pkg.sv
// tick_pkg
// Shared definitions for the tick generator / tick monitor pair.
//   tick_state_t : monitor FSM states
//   TICK_PERIOD  : default nominal tick spacing (generator N=5000 -> N+1)
//   TICK_TOL     : default allowed deviation either side of the period
//   cnt_width()  : bits needed to hold 0..max_val
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    ALARM  = 2'd3
  } tick_state_t;

  localparam int unsigned TICK_PERIOD = 5001;
  localparam int unsigned TICK_TOL    = 2;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_window.sv
// tick_window
// Gap counter and tolerance-window decode for the tick monitor.
// Ports:
//   clk      : clock
//   rst      : asynchronous reset, active low
//   run      : monitoring active (not IDLE, no clear this cycle)
//   tick_acc : accepted tick this cycle (tick and no clear)
//   good     : comb, tick inside [PERIOD-TOL, PERIOD+TOL]
//   early    : comb, tick before PERIOD-TOL
//   late     : comb, window closed at PERIOD+TOL without a tick
module tick_window
  import tick_pkg::*;
#(
  parameter int unsigned PERIOD = TICK_PERIOD,
  parameter int unsigned TOL    = TICK_TOL,
  parameter int unsigned CBITS  = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic tick_acc,
  output logic good,
  output logic early,
  output logic late
);

  localparam logic [CBITS-1:0] G_LO     = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] G_HI     = CBITS'(PERIOD + TOL);
  // After a late event the missing tick is assumed to have landed at
  // PERIOD, so the next cycle sits TOL+1 past that virtual tick.
  localparam logic [CBITS-1:0] G_RELOAD = CBITS'(TOL + 1);
  // g is the current cycle's distance from the last tick. The tick
  // cycle itself is distance 0, so the register restarts at 1.
  localparam logic [CBITS-1:0] G_START  = CBITS'(1);

  logic [CBITS-1:0] g;

  always_comb begin
    good  = run & tick_acc & (g >= G_LO) & (g <= G_HI);
    early = run & tick_acc & (g < G_LO);
    late  = run & ~tick_acc & (g == G_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g <= '0;
    end else if (tick_acc) begin
      g <= G_START;
    end else if (run) begin
      g <= late ? G_RELOAD : g + CBITS'(1);
    end
  end

endmodule

// File: rtl/tick_monitor.sv
// tick_monitor
// Checks that upstream tick pulses arrive at PERIOD +/- TOL cycles,
// reports lock, early/late pulses and a sticky alarm after repeated misses.
// Optional build macro TICK_MONITOR_STATS_EN adds early_cnt/late_cnt.
// Ports:
//   clk       : clock
//   rst       : asynchronous reset, active low
//   tick      : one-cycle pulse from the tick generator
//   clr       : synchronous clear to IDLE, drops alarm (wins over tick)
//   locked    : high while LOCKED
//   early     : one-cycle pulse, tick arrived before the window
//   late      : one-cycle pulse, window closed with no tick
//   alarm     : sticky, cleared by clr or reset
//   good_cnt  : wrapping count of in-window ticks (not cleared by clr)
//   early_cnt : (stats build) saturating early count
//   late_cnt  : (stats build) saturating late count
//
// state  | meaning
// IDLE   | waiting for first tick, gap counter frozen
// TRACK  | monitoring, not yet LOCK_N consecutive good ticks
// LOCKED | LOCK_N consecutive good ticks seen
// ALARM  | MISS_MAX consecutive misses seen, exit only via clr
module tick_monitor
  import tick_pkg::*;
#(
  parameter int unsigned PERIOD   = TICK_PERIOD,
  parameter int unsigned TOL      = TICK_TOL,
  parameter int unsigned CBITS    = 13,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned MISS_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clr,
  output logic        locked,
  output logic        early,
  output logic        late,
  output logic        alarm,
`ifdef TICK_MONITOR_STATS_EN
  output logic [7:0]  early_cnt,
  output logic [7:0]  late_cnt,
`endif
  output logic [15:0] good_cnt
);

  localparam int unsigned KBITS = cnt_width(LOCK_N);
  localparam int unsigned MBITS = cnt_width(MISS_MAX);
  localparam logic [KBITS-1:0] K_MAX = KBITS'(LOCK_N);
  localparam logic [MBITS-1:0] M_MAX = MBITS'(MISS_MAX);

  tick_state_t      state;
  logic [KBITS-1:0] k, k_nxt;
  logic [MBITS-1:0] m, m_nxt;
  logic             run, tick_acc, miss;
  logic             win_good, win_early, win_late;

  assign tick_acc = tick & ~clr;
  assign run      = (state != IDLE) & ~clr;
  assign miss     = win_early | win_late;

  tick_window #(
    .PERIOD(PERIOD),
    .TOL   (TOL),
    .CBITS (CBITS)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .tick_acc(tick_acc),
    .good    (win_good),
    .early   (win_early),
    .late    (win_late)
  );

  always_comb begin
    k_nxt = k;
    m_nxt = m;
    if (miss) begin
      k_nxt = '0;
      if (m != M_MAX) m_nxt = m + MBITS'(1);
    end else if (win_good) begin
      m_nxt = '0;
      if (k != K_MAX) k_nxt = k + KBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      m        <= '0;
      locked   <= 1'b0;
      alarm    <= 1'b0;
      early    <= 1'b0;
      late     <= 1'b0;
      good_cnt <= '0;
    end else if (clr) begin
      state  <= IDLE;
      k      <= '0;
      m      <= '0;
      locked <= 1'b0;
      alarm  <= 1'b0;
      early  <= 1'b0;
      late   <= 1'b0;
    end else begin
      k     <= k_nxt;
      m     <= m_nxt;
      early <= win_early;
      late  <= win_late;
      if (win_good) good_cnt <= good_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (tick_acc) state <= TRACK;
        end
        TRACK: begin
          if (miss && m_nxt == M_MAX) begin
            state <= ALARM;
            alarm <= 1'b1;
          end else if (win_good && k_nxt == K_MAX) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (miss) begin
            locked <= 1'b0;
            if (m_nxt == M_MAX) begin
              state <= ALARM;
              alarm <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end
        end
        ALARM: begin
          state <= ALARM;
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          alarm  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TICK_MONITOR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_cnt <= '0;
      late_cnt  <= '0;
    end else if (clr) begin
      early_cnt <= '0;
      late_cnt  <= '0;
    end else begin
      if (win_early && early_cnt != 8'hFF) early_cnt <= early_cnt + 8'd1;
      if (win_late && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor
// Directed scenarios followed by randomized tick spacing, clears and
// resets, checked every cycle against a gap/anchor reference model.
module tb_tick_monitor;

  localparam int P  = 8;
  localparam int T  = 1;
  localparam int LN = 2;
  localparam int MM = 2;

  localparam int M_IDLE   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_ALARM  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        clr = 1'b0;
  logic        locked, early, late, alarm;
  logic [15:0] good_cnt;
`ifdef TICK_MONITOR_STATS_EN
  logic [7:0]  early_cnt, late_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int cyc, anchor, mode, gs, ms;
  int x_early, x_late, x_good, x_ec, x_lc;

  always #5 clk = ~clk;

  tick_monitor #(
    .PERIOD  (P),
    .TOL     (T),
    .CBITS   (4),
    .LOCK_N  (LN),
    .MISS_MAX(MM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clr      (clr),
    .locked   (locked),
    .early    (early),
    .late     (late),
    .alarm    (alarm),
`ifdef TICK_MONITOR_STATS_EN
    .early_cnt(early_cnt),
    .late_cnt (late_cnt),
`endif
    .good_cnt (good_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; anchor = 0; mode = M_IDLE; gs = 0; ms = 0;
    x_early = 0; x_late = 0; x_good = 0; x_ec = 0; x_lc = 0;
  endtask

  task automatic model_step(input bit t, input bit c);
    int gap;
    bit ev_e, ev_l, ev_g;
    ev_e = 0; ev_l = 0; ev_g = 0;
    if (c) begin
      mode = M_IDLE; gs = 0; ms = 0;
      x_early = 0; x_late = 0; x_ec = 0; x_lc = 0;
    end else begin
      if (mode == M_IDLE) begin
        if (t) begin
          anchor = cyc;
          mode = M_TRACK;
        end
      end else begin
        gap = cyc - anchor;
        if (t) begin
          anchor = cyc;
          if (gap < P - T) ev_e = 1;
          else ev_g = 1;
        end else if (gap == P + T) begin
          ev_l = 1;
          anchor = cyc - T;  // virtual tick at P
        end
      end
      if (ev_g) begin
        x_good = (x_good + 1) % 65536;
        ms = 0;
        if (gs < LN) gs++;
      end
      if (ev_e || ev_l) begin
        gs = 0;
        if (ms < MM) ms++;
      end
      if (mode == M_TRACK) begin
        if ((ev_e || ev_l) && ms >= MM) mode = M_ALARM;
        else if (ev_g && gs >= LN) mode = M_LOCKED;
      end else if (mode == M_LOCKED) begin
        if (ev_e || ev_l) mode = (ms >= MM) ? M_ALARM : M_TRACK;
      end
      x_early = int'(ev_e);
      x_late  = int'(ev_l);
      if (ev_e && x_ec < 255) x_ec++;
      if (ev_l && x_lc < 255) x_lc++;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("locked",   32'(locked),   32'(mode == M_LOCKED));
    chk("alarm",    32'(alarm),    32'(mode == M_ALARM));
    chk("early",    32'(early),    32'(x_early));
    chk("late",     32'(late),     32'(x_late));
    chk("good_cnt", 32'(good_cnt), 32'(x_good));
`ifdef TICK_MONITOR_STATS_EN
    chk("early_cnt", 32'(early_cnt), 32'(x_ec));
    chk("late_cnt",  32'(late_cnt),  32'(x_lc));
`endif
  endtask

  task automatic step(input bit t, input bit c);
    tick = t;
    clr  = c;
    @(posedge clk);
    model_step(t, c);
    #1;
    tick = 1'b0;
    clr  = 1'b0;
    check_all();
  endtask

  task automatic gap_tick(input int gap);
    for (int j = 0; j < gap - 1; j++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  // Half-cycle reset pulse starting just after a rising edge.
  task automatic async_reset();
    rst = 1'b0;
    #2;
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_alarm",    32'(alarm),    32'd0);
    chk("rst_early",    32'(early),    32'd0);
    chk("rst_late",     32'(late),     32'd0);
    chk("rst_good_cnt", 32'(good_cnt), 32'd0);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int r, gap;
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset_good_cnt", 32'(good_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // regular ticks: lock after the third
    step(1'b1, 1'b0);
    gap_tick(8);
    gap_tick(8);
    chk("lock_after_3", 32'(locked), 32'd1);
    chk("good_after_3", 32'(good_cnt), 32'd2);

    // window edges
    gap_tick(7);
    chk("gap7_good", 32'(good_cnt), 32'd3);
    chk("gap7_locked", 32'(locked), 32'd1);
    gap_tick(9);
    chk("gap9_good", 32'(good_cnt), 32'd4);
    chk("gap9_locked", 32'(locked), 32'd1);

    // early tick drops lock
    gap_tick(5);
    chk("early_pulse", 32'(early), 32'd1);
    chk("early_unlock", 32'(locked), 32'd0);
    chk("early_no_alarm", 32'(alarm), 32'd0);
    step(1'b0, 1'b0);
    chk("early_one_cycle", 32'(early), 32'd0);
    gap_tick(7);
    gap_tick(8);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_good", 32'(good_cnt), 32'd6);

    // ticks stop: two late pulses raise alarm
    repeat (8) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("late1", 32'(late), 32'd1);
    chk("late1_unlock", 32'(locked), 32'd0);
    repeat (7) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("late2", 32'(late), 32'd1);
    chk("late2_alarm", 32'(alarm), 32'd1);
    gap_tick(7);
    gap_tick(8);
    gap_tick(8);
    chk("alarm_sticky", 32'(alarm), 32'd1);
    chk("alarm_good_live", 32'(good_cnt), 32'd9);

    // clear together with a tick
    repeat (7) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("clr_alarm", 32'(alarm), 32'd0);
    chk("clr_good_kept", 32'(good_cnt), 32'd9);
    repeat (12) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("first_not_counted", 32'(good_cnt), 32'd9);
    gap_tick(8);
    gap_tick(8);
    chk("clr_relock", 32'(locked), 32'd1);
    gap_tick(8);
    chk("clr_good", 32'(good_cnt), 32'd12);

    // async reset while locked
    async_reset();
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("post_rst_first", 32'(good_cnt), 32'd0);
    gap_tick(8);
    chk("post_rst_second", 32'(good_cnt), 32'd1);

    // randomized spacing, clears and resets
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) async_reset();
      if (r < 12) gap = int'($urandom_range(12, 25));
      else gap = int'($urandom_range(4, 11));
      for (int j = 0; j < gap - 1; j++) step(1'b0, $urandom_range(0, 59) == 0);
      step(1'b1, $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Period monitor directly downstream of the delay/tick generator: consumes its one-cycle `sig` pulse stream and checks that pulses arrive at the nominal period within a tolerance window. It reports lock, early and late pulses, and a sticky alarm after repeated misses. Status feeds the system health logic.

## Interface
Parameters:
- `PERIOD`, 5001: nominal cycles between ticks. This matches the generator's N+1 spacing for N=5000.
- `TOL`, 2: allowed deviation in cycles, either side of `PERIOD`.
- `CBITS`, 13: gap counter width. Must hold `PERIOD+TOL`.
- `LOCK_N`, 4: consecutive in-window ticks required to lock.
- `MISS_MAX`, 3: consecutive misses (early or late) that raise the alarm.

Ports:
- `clk  input  1` — the single clock. All logic is on the rising edge.
- `rst  input  1` — asynchronous, active-low reset. Asserted when 0.
- `tick  input  1` — one-cycle pulse from the upstream generator's `sig`.
- `clr  input  1` — synchronous clear. Returns the block to IDLE and drops the alarm.
- `locked  output  1` — level. High while in LOCKED.
- `early  output  reg 1` — one-cycle pulse: a tick arrived before the window.
- `late  output  1` — one-cycle pulse: the window closed with no tick.
- `alarm  output  1` — sticky. Cleared only by `clr` or reset.
- `good_cnt  output  16` — count of in-window ticks. Wraps.

## Operation
- Gap counter `g`, CBITS wide. Set to 0 in the cycle a tick is accepted, otherwise incremented by 1.
- Window test for a tick at gap `g`:
  - good: `PERIOD-TOL <= g <= PERIOD+TOL`
  - early: `g < PERIOD-TOL`
- Late: `g == PERIOD+TOL` with no tick. The block then treats a virtual tick as having occurred at `PERIOD`, so `g` is reloaded to `TOL+1` to keep the schedule aligned.
- A tick at exactly `g == PERIOD+TOL` is good, not late.
- Miss counter `m`: incremented on each early or late event, zeroed on each good tick. Lock counter `k`: incremented on each good tick, zeroed on each miss.
- States: IDLE, TRACK, LOCKED, ALARM.
  - IDLE: `g` and the checks are frozen. The first tick sets `g=0` and moves to TRACK. That tick is not counted as good.
  - TRACK → LOCKED: when `k` reaches `LOCK_N`.
  - TRACK or LOCKED → ALARM: when `m` reaches `MISS_MAX`.
  - LOCKED → TRACK: on any single miss; `k` is zeroed.
  - ALARM: monitoring continues, so `early`, `late` and `good_cnt` stay live. The state is exited only via `clr`, which goes to IDLE.
- `good_cnt` increments by 1 per good tick and wraps from 0xFFFF to 0. It is never cleared by `clr`.
- `clr` and `tick` in the same cycle: `clr` wins and the tick is ignored.
- Counters `k` and `m` saturate at `LOCK_N` and `MISS_MAX` respectively.

## Timing
- Every output is registered.
  - `early`, `late` and `good_cnt` update in the cycle after the triggering event.
  - `locked` and `alarm` follow the state register; they are high from the cycle after the transition.
- Reset values:
  - outputs: `locked=0`, `early=0`, `late=0`, `alarm=0`, `good_cnt=0`
  - state IDLE; `g`, `m`, `k` = 0.
- Reset asserted mid-operation clears everything immediately, independent of `clk`.
- `early` and `late` never assert in the same cycle.

## Configuration
- `TICK_MONITOR_STATS_EN` defined: two extra outputs are present.
  - `early_cnt[7:0]` and `late_cnt[7:0]`, saturating at 255.
  - Cleared by reset and by `clr`.
- Not defined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `tick_pkg` holds:
  - the state enum `tick_state_t` (IDLE, TRACK, LOCKED, ALARM);
  - the default `PERIOD`/`TOL` constants, shared with the generator.
- One natural sub-module: `tick_window`. It owns gap counter `g` and emits combinational `good`, `early` and `late` decodes to the FSM. The top module holds the FSM, the `m`/`k` counters and the output registers.

## Test plan
All scenarios use `PERIOD=8`, `TOL=1`, `LOCK_N=2`, `MISS_MAX=2`.
- Ticks every 8 cycles from reset release → `locked=1` one cycle after the third tick; `good_cnt=2`; `early` and `late` never assert.
- Locked, then ticks at gap 7 and then gap 9 → both good; `good_cnt` increments each time and `locked` stays 1.
- Locked, then a tick at gap 5 → `early` pulses for 1 cycle; `locked` drops to 0; state is TRACK.
- Locked, then ticks stop → `late` pulses at gap 9 and again 8 cycles later. `alarm=1` after the second late pulse and stays high while ticks resume at gap 8.
- In ALARM, `clr` asserted in the same cycle as a tick → IDLE, `alarm=0`, tick ignored; `good_cnt` unchanged.
- `rst` pulled low for half a cycle while locked with `good_cnt=5` → all outputs 0 immediately; the next tick is treated as the first tick.
